// File: rtl/slow_tick_bcd_counter.sv
// Multi-digit BCD up/down event counter stepped by rising edges of a slow
// divided level, which is sampled as data in the single clk domain.
module slow_tick_bcd_counter #(
  parameter int DIGITS = 4,
  parameter int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         dividedClk,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  output logic [W-1:0] bcd,
  output logic         tick,
  output logic         wrap
);

  logic         prev;
  logic         rise;
  logic [W-1:0] count_next;
  logic         count_wrap;
  logic [W-1:0] load_clean;
  logic [3:0]   digit;
  logic         chain;

  // prev tracks the input even in reset so a high level after reset is not an edge
  always_ff @(posedge clk) begin
    prev <= dividedClk;
  end

  assign rise = dividedClk & ~prev;

  always_comb begin
    count_next = bcd;
    chain      = 1'b1;
    digit      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = bcd[4*i +: 4];
      if (chain) begin
        if (up) begin
          if (digit >= 4'd9) begin
            count_next[4*i +: 4] = 4'd0;
          end else begin
            count_next[4*i +: 4] = digit + 4'd1;
            chain                = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            count_next[4*i +: 4] = 4'd9;
          end else begin
            count_next[4*i +: 4] = digit - 4'd1;
            chain                = 1'b0;
          end
        end
      end
    end
    // carry/borrow out of the top digit means every digit rolled over
    count_wrap = chain;
  end

  always_comb begin
    load_clean = loadValue;
    for (int i = 0; i < DIGITS; i++) begin
      if (loadValue[4*i +: 4] > 4'd9) begin
        load_clean[4*i +: 4] = 4'd9;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      bcd  <= load_clean;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (rise && enable) begin
      bcd  <= count_next;
      tick <= 1'b1;
      wrap <= count_wrap;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slow_tick_bcd_counter.sv
// Scoreboard bench for slow_tick_bcd_counter: a decimal-integer model pushes
// expected outputs per clock edge; a monitor pops and compares after each edge.
module tb_slow_tick_bcd_counter;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         dividedClk;
  logic         up;
  logic         load;
  logic [W-1:0] loadValue;
  logic [W-1:0] bcd;
  logic         tick;
  logic         wrap;

  typedef struct {
    logic [W-1:0] bcd;
    logic         tick;
    logic         wrap;
  } exp_t;

  exp_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   tickSeen   = 0;
  int   wrapSeen   = 0;
  int   mCount     = 0;
  bit   mPrev      = 1'b0;

  slow_tick_bcd_counter #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .dividedClk(dividedClk),
    .up        (up),
    .load      (load),
    .loadValue (loadValue),
    .bcd       (bcd),
    .tick      (tick),
    .wrap      (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [W-1:0] toBcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int sanitizedValue(input logic [W-1:0] lv);
    int v;
    int d;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  // Model the upcoming posedge from the inputs currently driven, then let n edges pass
  task automatic applyStimulus(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.tick = 1'b0;
      e.wrap = 1'b0;
      if (reset) begin
        mCount = 0;
      end else if (load) begin
        mCount = sanitizedValue(loadValue);
      end else if (dividedClk && !mPrev && enable) begin
        e.tick = 1'b1;
        if (up) begin
          if (mCount == MAXV) begin mCount = 0; e.wrap = 1'b1; end
          else mCount = mCount + 1;
        end else begin
          if (mCount == 0) begin mCount = MAXV; e.wrap = 1'b1; end
          else mCount = mCount - 1;
        end
      end
      mPrev = dividedClk;
      e.bcd = toBcd(mCount);
      expq.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic pulseEdges(input int n);
    for (int k = 0; k < n; k++) begin
      dividedClk = 1'b0;
      applyStimulus(3);
      dividedClk = 1'b1;
      applyStimulus(3);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checkOutput("bcd", {16'd0, bcd}, {16'd0, e.bcd});
      checkOutput("tick", {31'd0, tick}, {31'd0, e.tick});
      checkOutput("wrap", {31'd0, wrap}, {31'd0, e.wrap});
      if (tick === 1'b1) tickSeen++;
      if (wrap === 1'b1) wrapSeen++;
    end
  end

  initial begin
    int guard;
    reset      = 1'b1;
    enable     = 1'b1;
    dividedClk = 1'b1;
    up         = 1'b1;
    load       = 1'b0;
    loadValue  = '0;
    @(negedge clk);

    // reset with input already high: no spurious edge afterwards
    applyStimulus(3);
    reset = 1'b0;
    applyStimulus(10);
    checkOutput("reset_bcd", {16'd0, bcd}, 32'h0000);
    checkOutput("reset_ticks", tickSeen, 0);

    tickSeen = 0;
    pulseEdges(12);
    checkOutput("count12_bcd", {16'd0, bcd}, 32'h0012);
    checkOutput("count12_ticks", tickSeen, 12);
    checkOutput("count12_wraps", wrapSeen, 0);

    dividedClk = 1'b0;
    load       = 1'b1;
    loadValue  = 16'h9998;
    applyStimulus(1);
    load = 1'b0;
    pulseEdges(1);
    checkOutput("up_9999", {16'd0, bcd}, 32'h9999);
    pulseEdges(1);
    checkOutput("up_wrap_bcd", {16'd0, bcd}, 32'h0000);
    checkOutput("up_wrap_count", wrapSeen, 1);
    up = 1'b0;
    pulseEdges(1);
    checkOutput("down_wrap_bcd", {16'd0, bcd}, 32'h9999);
    checkOutput("down_wrap_count", wrapSeen, 2);

    dividedClk = 1'b0;
    load       = 1'b1;
    loadValue  = 16'h1A3F;
    applyStimulus(1);
    load = 1'b0;
    applyStimulus(2);
    checkOutput("load_sanitize", {16'd0, bcd}, 32'h1939);

    // load coincident with a rising edge: edge is discarded
    tickSeen   = 0;
    up         = 1'b1;
    dividedClk = 1'b1;
    load       = 1'b1;
    loadValue  = 16'h0040;
    applyStimulus(1);
    load = 1'b0;
    applyStimulus(3);
    checkOutput("load_edge_bcd", {16'd0, bcd}, 32'h0040);
    checkOutput("load_edge_ticks", tickSeen, 0);

    enable = 1'b0;
    pulseEdges(3);
    enable = 1'b1;
    pulseEdges(2);
    checkOutput("enable_bcd", {16'd0, bcd}, 32'h0042);
    checkOutput("enable_ticks", tickSeen, 2);

    dividedClk = 1'b0;
    load       = 1'b1;
    loadValue  = 16'h0500;
    applyStimulus(1);
    load = 1'b0;
    applyStimulus(2);
    tickSeen   = 0;
    dividedClk = 1'b1;
    reset      = 1'b1;
    applyStimulus(1);
    checkOutput("reset_edge_bcd", {16'd0, bcd}, 32'h0000);
    reset = 1'b0;
    applyStimulus(3);
    checkOutput("reset_edge_ticks", tickSeen, 0);
    pulseEdges(1);
    checkOutput("after_reset_bcd", {16'd0, bcd}, 32'h0001);

    // random direction/enable/load traffic against the model
    for (int k = 0; k < 40; k++) begin
      up         = 1'($urandom_range(0, 1));
      enable     = ($urandom_range(0, 3) != 0);
      load       = ($urandom_range(0, 9) == 0);
      loadValue  = 16'($urandom);
      dividedClk = 1'($urandom_range(0, 1));
      applyStimulus(1);
    end
    load = 1'b0;
    applyStimulus(2);

    guard = 0;
    while (expq.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("scoreboard_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/slow_tick_bcd_counter.md
# slow_tick_bcd_counter

Decimal event counter that sits directly downstream of the overflow clock divider on the Nexys4 DDR board. It takes the divider's slow square wave (`dividedClk`) as an ordinary data input and detects its rising edges synchronously in the `clk` domain. On each detected edge it steps a multi-digit BCD counter up or down, with load and wrap signalling. Its BCD output feeds the seven-segment display path; the divided signal is never used as a clock.

## Interface

Parameters:
- `DIGITS`, default 4: number of BCD digits, legal range 1..8.
- `W`, default 4*DIGITS: derived width of the BCD bus; not overridden.

Ports:
- `clk` input 1: system clock, 100 MHz on board. This is the only clock.
- `reset` input 1: reset, synchronous and active-high.
- `enable` input 1: when 0, detected edges are ignored and no count occurs.
- `dividedClk` input 1: slow level from the divider; treated as data.
- `up` input 1: count direction; 1 = increment, 0 = decrement.
- `load` input 1: synchronous load strobe.
- `loadValue` input W: BCD value to load; nibble 0 is the least significant digit.
- `bcd` output W: current count, registered.
- `tick` output 1: one-cycle pulse on every count step.
- `wrap` output 1: one-cycle pulse when the count rolls over (up) or under (down).

## Operation

Edge detection:
- Register `prev` holds the value of `dividedClk` sampled on the previous `clk` edge.
- `edge = dividedClk & ~prev`.
- During reset, `prev` still loads `dividedClk`. This prevents a spurious edge on the first cycle after reset when `dividedClk` is already high.

Reset values (every output): `bcd` = 0, `tick` = 0, `wrap` = 0.

Priority order, evaluated at each `clk` edge:
1. `reset`.
2. `load`: `bcd` <= `loadValue`, sanitised per nibble (any nibble >9 is stored as 9). `tick` = 0 and `wrap` = 0. A coincident edge is discarded, not deferred.
3. `edge & enable`: count one step, `tick` = 1.
4. Otherwise: `bcd` holds, `tick` = 0, `wrap` = 0.

Count arithmetic:
- Per-digit BCD with ripple carry/borrow, computed combinationally within one cycle.
- Up: a digit at 9 goes to 0 and carries into the next digit. When all digits are 9, the result is all 0s and `wrap` = 1.
- Down: a digit at 0 goes to 9 and borrows from the next digit. When all digits are 0, the result is all 9s and `wrap` = 1.
- No state ever holds a nibble >9.

Other rules:
- `up` is sampled only on the counting edge. Changing it between edges has no effect.
- `enable` low while `dividedClk` rises: that edge is lost permanently, with no catch-up when `enable` returns high. `prev` keeps tracking regardless of `enable`.

## Timing

- Latency: `bcd`, `tick` and `wrap` update on the first `clk` edge that samples `dividedClk` = 1 after a sample of 0. `tick` and `wrap` are valid in the cycle following that edge.
- `tick` and `wrap` are exactly one `clk` cycle wide. `wrap` is asserted only together with `tick`.
- Minimum spacing between two counts is 2 `clk` cycles, since `dividedClk` must be sampled low in between. The divider's period of 2^27 cycles is far above this.
- Falling edges of `dividedClk` have no effect.
- Load takes effect on the edge where `load` = 1; the new `bcd` is visible in the next cycle.
- Reset asserted mid-operation clears all outputs on that edge, including any edge coincident with reset. Counting resumes on the next detected rising edge after `reset` deasserts.

## Test plan

- Reset with `dividedClk` held at 1 for 3 cycles, then release and keep it high 10 cycles -> `bcd` = 0000, `tick` never asserts.
- `up` = 1, `enable` = 1, apply 12 rising edges of `dividedClk` (low 3 / high 3 cycles) from 0 -> `bcd` = 0x0012, 12 `tick` pulses each 1 cycle wide, `wrap` never asserts.
- Load 0x9998, `up` = 1, two edges -> `bcd` goes 9999 then 0000; `wrap` = 1 only on the second `tick`. Then `up` = 0, one edge -> 9999 with `wrap` = 1.
- Load 0x1A3F -> `bcd` = 0x1939. Load asserted on the same cycle as an edge -> `bcd` = `loadValue`, `tick` = 0.
- `enable` = 0 across 3 edges, then `enable` = 1 for 2 edges, starting from 0x0040 -> `bcd` = 0x0042, exactly 2 `tick` pulses.
- Reset asserted on the cycle of a detected edge at count 0x0500 -> `bcd` = 0000, `tick` = 0. The next edge after release gives 0001.
